// File: rtl/sgf_round_if.sv
// Handshake bundle for the significand rounding unit: input beat stream and
// rounded-result stream, each with valid/ready.
interface sgf_round_if #(
  parameter int SW = 23
);
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_sgf;
  logic [1:0]    in_grs;
  logic          in_sign;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sgf;
  logic          out_carry;
  logic          out_inc;
  logic          out_inexact;
  logic          out_sign;

  modport master (
    output in_valid, in_sgf, in_grs, in_sign, in_mode, out_ready,
    input  in_ready, out_valid, out_sgf, out_carry, out_inc, out_inexact, out_sign
  );

  modport slave (
    input  in_valid, in_sgf, in_grs, in_sign, in_mode, out_ready,
    output in_ready, out_valid, out_sgf, out_carry, out_inc, out_inexact, out_sign
  );
endinterface

// File: rtl/sgf_round_unit.sv
// Two-stage significand rounding unit: stage 1 decides the increment, stage 2
// adds it with carry-out. Saturating counter tracks delivered round-ups.
module sgf_round_unit #(
  parameter int SW     = 23,
  parameter bit RNE_EN = 1'b1,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  sgf_round_if.slave    bus,
  input  logic          clr_count,
  output logic [CW-1:0] inc_count
);

  logic          s1_valid;
  logic [SW-1:0] s1_sgf;
  logic          s1_sign;
  logic          s1_inc;
  logic          s1_inexact;

  logic          out_valid;
  logic [SW-1:0] out_sgf;
  logic          out_carry;
  logic          out_inc;
  logic          out_inexact;
  logic          out_sign;

  logic          s1_en;
  logic          s2_en;
  logic          xfer_out;
  logic          inc_c;
  logic          inexact_c;
  logic [SW:0]   sum;

  assign s2_en        = ~out_valid | bus.out_ready;
  assign s1_en        = ~s1_valid | s2_en;
  assign xfer_out     = out_valid & bus.out_ready;
  assign bus.in_ready = s1_en;

  always_comb begin
    inexact_c = |bus.in_grs;
    inc_c     = 1'b0;
    case (bus.in_mode)
      2'b00:   inc_c = RNE_EN & bus.in_grs[1] & (bus.in_grs[0] | bus.in_sgf[0]);
      2'b01:   inc_c = bus.in_sign & inexact_c;
      2'b10:   inc_c = ~bus.in_sign & inexact_c;
      default: inc_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_sgf     <= '0;
      s1_sign    <= 1'b0;
      s1_inc     <= 1'b0;
      s1_inexact <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sgf     <= bus.in_sgf;
        s1_sign    <= bus.in_sign;
        s1_inc     <= inc_c;
        s1_inexact <= inexact_c;
      end
    end
  end

  // Extra top bit of the sum is the carry into the exponent.
  assign sum = {1'b0, s1_sgf} + {{SW{1'b0}}, s1_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_sgf     <= '0;
      out_carry   <= 1'b0;
      out_inc     <= 1'b0;
      out_inexact <= 1'b0;
      out_sign    <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sgf     <= sum[SW-1:0];
        out_carry   <= sum[SW];
        out_inc     <= s1_inc;
        out_inexact <= s1_inexact;
        out_sign    <= s1_sign;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_count <= '0;
    end else if (clr_count) begin
      inc_count <= '0;
    end else if (xfer_out && out_inc && inc_count != {CW{1'b1}}) begin
      inc_count <= inc_count + CW'(1);
    end
  end

  assign bus.out_valid   = out_valid;
  assign bus.out_sgf     = out_sgf;
  assign bus.out_carry   = out_carry;
  assign bus.out_inc     = out_inc;
  assign bus.out_inexact = out_inexact;
  assign bus.out_sign    = out_sign;

endmodule

// File: tb/tb_sgf_round_unit.sv
// Bench for sgf_round_unit: an RNE_EN=1 and an RNE_EN=0 instance share one
// stimulus stream and are checked every cycle against a queue-based model.
module tb_sgf_round_unit;
  localparam int SW   = 23;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam longint MOD = longint'(1) << SW;

  typedef struct packed {
    logic [SW-1:0] sgf;
    logic          carry;
    logic          inc;
    logic          inexact;
    logic          sign;
  } res_t;

  typedef struct {
    int   tag;
    res_t r1;
    res_t r0;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_count = 1'b0;
  logic [CW-1:0] cnt1, cnt0;

  always #5 clk = ~clk;

  sgf_round_if #(.SW(SW)) bus ();
  sgf_round_if #(.SW(SW)) bus0 ();

  assign bus0.in_valid  = bus.in_valid;
  assign bus0.in_sgf    = bus.in_sgf;
  assign bus0.in_grs    = bus.in_grs;
  assign bus0.in_sign   = bus.in_sign;
  assign bus0.in_mode   = bus.in_mode;
  assign bus0.out_ready = bus.out_ready;

  sgf_round_unit #(.SW(SW), .RNE_EN(1'b1), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .clr_count(clr_count), .inc_count(cnt1)
  );
  sgf_round_unit #(.SW(SW), .RNE_EN(1'b0), .CW(CW)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .clr_count(clr_count), .inc_count(cnt0)
  );

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  int   edge_n = 0;
  int   mcnt1 = 0;
  int   mcnt0 = 0;
  int   popped = 0;
  bit   saw_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference rounding from the meaning of the discarded fraction.
  function automatic res_t ref_round(input logic [SW-1:0] sgf, input logic [1:0] grs,
                                     input logic sign, input logic [1:0] mode, input bit rne);
    res_t   r;
    longint sum;
    int     rem;
    bit     up;
    // rem: 0 nothing discarded, 1 below half, 2 exactly half, 3 above half
    rem = grs[1] ? (grs[0] ? 3 : 2) : (grs[0] ? 1 : 0);
    case (mode)
      2'd0:    up = rne && (rem == 3 || (rem == 2 && sgf[0]));
      2'd1:    up = sign && rem != 0;
      2'd2:    up = !sign && rem != 0;
      default: up = 1'b0;
    endcase
    sum       = longint'(sgf) + (up ? 64'd1 : 64'd0);
    r.sgf     = SW'(sum % MOD);
    r.carry   = (sum >= MOD);
    r.inc     = up;
    r.inexact = (rem != 0);
    r.sign    = sign;
    return r;
  endfunction

  function automatic bit front_visible();
    return q.size() > 0 && edge_n >= q[0].tag + 2;
  endfunction

  bit   m_vexp, m_ir, m_xin, m_xout;
  res_t m_act1, m_act0;
  ent_t m_ent;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mcnt1 = 0;
      mcnt0 = 0;
    end else begin
      m_vexp = front_visible();
      m_ir   = (q.size() < 2) || bus.out_ready;
      chk("in_ready", bus.in_ready, m_ir);
      chk("in_ready0", bus0.in_ready, m_ir);
      chk("out_valid", bus.out_valid, m_vexp);
      chk("out_valid0", bus0.out_valid, m_vexp);
      chk("inc_count", cnt1, mcnt1);
      chk("inc_count0", cnt0, mcnt0);
      if (m_vexp) begin
        m_act1 = {bus.out_sgf, bus.out_carry, bus.out_inc, bus.out_inexact, bus.out_sign};
        m_act0 = {bus0.out_sgf, bus0.out_carry, bus0.out_inc, bus0.out_inexact, bus0.out_sign};
        chk("out_data", m_act1, q[0].r1);
        chk("out_data0", m_act0, q[0].r0);
      end
      m_xin  = bus.in_valid && m_ir;
      m_xout = m_vexp && bus.out_ready;
      if (m_xout) begin
        if (q[0].r1.inc && mcnt1 < CMAX) mcnt1++;
        if (q[0].r0.inc && mcnt0 < CMAX) mcnt0++;
        void'(q.pop_front());
        popped++;
      end
      if (clr_count) begin
        mcnt1 = 0;
        mcnt0 = 0;
      end
      if (m_xin) begin
        m_ent.tag = edge_n;
        m_ent.r1  = ref_round(bus.in_sgf, bus.in_grs, bus.in_sign, bus.in_mode, 1'b1);
        m_ent.r0  = ref_round(bus.in_sgf, bus.in_grs, bus.in_sign, bus.in_mode, 1'b0);
        q.push_back(m_ent);
      end
      edge_n++;
    end
  end

  task automatic drive(input logic [SW-1:0] sgf, input logic [1:0] grs,
                       input logic sign, input logic [1:0] mode);
    bus.in_sgf  = sgf;
    bus.in_grs  = grs;
    bus.in_sign = sign;
    bus.in_mode = mode;
  endtask

  task automatic new_beat(input int kind);
    logic [SW-1:0] s;
    s = SW'($urandom);
    if (kind == 1) begin
      drive(s, 2'b01, 1'b0, 2'd2);
    end else begin
      if ($urandom_range(0, 3) == 0) s = '1;
      drive(s, 2'($urandom), 1'($urandom), 2'($urandom));
    end
  endtask

  // One beat into an empty pipeline; results checked against literals.
  task automatic directed(input string nm, input logic [SW-1:0] sgf, input logic [1:0] grs,
                          input logic sign, input logic [1:0] mode,
                          input logic [SW-1:0] e_sgf, input logic e_carry, input logic e_inc,
                          input logic e_inexact, input logic e_inc0);
    @(posedge clk); #1;
    drive(sgf, grs, sign, mode);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_early"}, bus.out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_valid"}, bus.out_valid, 1'b1);
    chk({nm, "_sgf"}, bus.out_sgf, e_sgf);
    chk({nm, "_carry"}, bus.out_carry, e_carry);
    chk({nm, "_inc"}, bus.out_inc, e_inc);
    chk({nm, "_inexact"}, bus.out_inexact, e_inexact);
    chk({nm, "_sign"}, bus.out_sign, sign);
    chk({nm, "_inc0"}, bus0.out_inc, e_inc0);
  endtask

  task automatic run_stream(input int n, input int slo, input int shi, input bit rnd, input int kind);
    int sent = 0;
    int cyc  = 0;
    bit hs;
    @(posedge clk); #1;
    new_beat(kind);
    bus.in_valid  = 1'b1;
    bus.out_ready = !(cyc >= slo && cyc <= shi);
    while (sent < n && cyc < 5000) begin
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      if (!bus.in_ready) saw_stall = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (hs) sent++;
      if (hs || !bus.in_valid) begin
        if (sent < n && (!rnd || $urandom_range(0, 4) != 0)) begin
          new_beat(kind);
          bus.in_valid = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (cyc >= slo && cyc <= shi) bus.out_ready = 1'b0;
      else bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    bus.in_valid = 1'b0;
    chk("stream_sent", sent, n);
  endtask

  task automatic drain();
    int k = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (q.size() != 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  int p0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive('0, 2'b00, 1'b0, 2'd0);
    #2;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_inc_count", cnt1, 0);
    chk("rst_out_sgf", bus.out_sgf, 0);
    chk("model_pin_carry", ref_round('1, 2'b01, 1'b1, 2'd1, 1'b1), {{SW{1'b0}}, 1'b1, 1'b1, 1'b1, 1'b1});
    chk("model_pin_tie", ref_round(23'h3, 2'b10, 1'b0, 2'd0, 1'b1), {23'h4, 1'b0, 1'b1, 1'b1, 1'b0});
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    directed("rne_up",    23'h000001, 2'b10, 1'b0, 2'd0, 23'h000002, 1'b0, 1'b1, 1'b1, 1'b0);
    directed("rne_tie",   23'h000002, 2'b10, 1'b0, 2'd0, 23'h000002, 1'b0, 1'b0, 1'b1, 1'b0);
    directed("rdn_carry", 23'h7FFFFF, 2'b01, 1'b1, 2'd1, 23'h000000, 1'b1, 1'b1, 1'b1, 1'b1);
    directed("rdn_pos",   23'h7FFFFF, 2'b01, 1'b0, 2'd1, 23'h7FFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    directed("rup_exact", 23'h123456, 2'b00, 1'b0, 2'd2, 23'h123456, 1'b0, 1'b0, 1'b0, 1'b0);
    directed("trunc",     23'h0ABCDE, 2'b11, 1'b0, 2'd3, 23'h0ABCDE, 1'b0, 1'b0, 1'b1, 1'b0);
    directed("rne_above", 23'h0ABCDE, 2'b11, 1'b1, 2'd0, 23'h0ABCDF, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();

    run_stream(20, -1, -1, 1'b0, 1);
    drain();
    @(negedge clk);
    chk("count_sat", cnt1, 15);

    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    new_beat(1);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    clr_count     = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    chk("count_clr_wins", cnt1, 0);
    chk("count_clr_wins0", cnt0, 0);

    saw_stall = 1'b0;
    p0 = popped;
    run_stream(8, 3, 6, 1'b0, 0);
    drain();
    chk("bp_in_ready_fell", saw_stall, 1'b1);
    chk("bp_delivered", popped - p0, 8);

    run_stream(300, -1, -1, 1'b1, 0);
    drain();

    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    new_beat(1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.in_ready) break;
    end
    chk("fill_in_ready_low", bus.in_ready, 1'b0);
    @(posedge clk); #3;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_inc_count", cnt1, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b1);
    chk("mid_rst_out_sgf", bus.out_sgf, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    directed("post_rst", 23'h000001, 2'b10, 1'b0, 2'd0, 23'h000002, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sgf_round_unit.md
# sgf_round_unit

Parametrised, pipelined significand rounding unit for the floating-point datapath. It supports round-to-nearest-even, toward −∞, toward +∞ and truncation. It takes a truncated significand plus guard/sticky bits and sign, decides the increment, performs the add with carry-out, and flags inexact results. It sits between normalisation and exponent adjust/packing. Two register stages with valid/ready backpressure; a saturating counter records round-up events.

## Interface
- SW, 23: significand width in bits (23 single, 52 double); legal 4..64
- RNE_EN, 1: 1 = mode 2'b00 is round-to-nearest-even; 0 = mode 2'b00 truncates
- CW, 16: width of round-up event counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  unit accepts input this cycle
- in_sgf  in  SW  truncated significand
- in_grs  in  2  [1] guard bit, [0] sticky (round|sticky OR)
- in_sign  in  1  sign of value being rounded (1 = negative)
- in_mode  in  2  00 nearest-even (per RNE_EN), 01 toward −∞, 10 toward +∞, 11 truncate
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_sgf  out  SW  rounded significand (low SW bits of sum)
- out_carry  out  1  increment overflowed SW bits (exponent must +1)
- out_inc  out  1  increment applied
- out_inexact  out  1  in_grs != 0
- out_sign  out  1  in_sign passthrough
- clr_count  in  1  synchronous clear of inc_count
- inc_count  out  CW  saturating count of transferred results with out_inc = 1

## Operation
- inexact = grs[1] | grs[0]
- Increment decision inc:
  - mode 00, RNE_EN=1: grs[1] & (grs[0] | in_sgf[0])
  - mode 01: in_sign & inexact
  - mode 10: ~in_sign & inexact
  - mode 11, or mode 00 with RNE_EN=0: 0
- Stage 1 registers sgf, sign, inc, inexact.
- Stage 2 computes {carry, sgf} = {1'b0, sgf} + inc in SW+1 bits and registers the result.
- Carry occurs only for sgf all-ones with inc=1; then out_sgf = 0 and out_carry = 1.
- Counter increments on each output transfer (out_valid & out_ready) with out_inc = 1.
  - Holds at all-ones; never wraps.
  - clr_count asserted in the same cycle as a counted transfer: clear wins, result 0.
- No state machine beyond per-stage valid bits; each stage is empty or full.

## Timing
- Handshake: transfer on rising edge when valid & ready.
  - out_valid and the out_* data stay stable while out_valid & ~out_ready.
  - Producer must hold its input stable while in_valid & ~in_ready.
- Enables:
  - s2_en = ~out_valid | out_ready
  - s1_en = ~s1_valid | s2_en
  - in_ready = s1_en (combinational; no combinational in_valid→out_valid path)
- Latency: beat accepted at edge N appears on outputs after edge N+1 (2 register stages).
- Throughput 1 beat/cycle when out_ready is held high.
- Full pipeline plus out_ready low: in_ready low.
  - When out_ready rises, in_ready rises in the same cycle, so no bubble.
- Simultaneous accept at input and transfer at output in a full pipeline: both occur and order is preserved.
- Reset (async assert, any time including mid-transfer):
  - s1_valid, out_valid, out_sgf, out_carry, out_inc, out_inexact, out_sign and inc_count go to 0.
  - in_ready is 1 while reset is held low and after its release.
  - In-flight beats are discarded.
- Reset deassertion is synchronous to clk, handled externally.

## Test plan
- SW=23, mode 00, sgf=0x000001, grs=2'b10 → after 2 edges out_sgf=0x000002, inc=1, inexact=1, carry=0. Same with sgf=0x000002 → out_sgf=0x000002, inc=0 (tie to even).
- Mode 01: sign=1, sgf=0x7FFFFF, grs=2'b01 → out_sgf=0x000000, carry=1, inc=1. Sign=0, same data → out_sgf=0x7FFFFF, inc=0, inexact=1.
- Mode 10: sign=0, grs=2'b00 → inc=0, inexact=0. Mode 11, grs=2'b11 → inc=0, inexact=1. RNE_EN=0, mode 00, grs=2'b11 → inc=0.
- Backpressure: stream of 8 beats with in_valid=1; hold out_ready=0 for cycles 3..6.
  - in_ready falls once both stages fill.
  - All 8 results arrive in order, no loss or duplication, outputs stable while stalled.
- Counter: CW=4, 20 transfers with inc=1 → inc_count=15. Assert clr_count with a counted transfer → inc_count=0 next cycle.
- Assert rst_n low mid-stream with both stages full → out_valid=0 and inc_count=0 immediately. After release, the first new beat emerges after 2 edges.
